float_accumulator: RTL and testbench

FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

---
 rtl/float_accumulator.sv | 144 ++++++++++++++
 tb/tb_float_accumulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/float_accumulator.sv
// float_accumulator
//   Sums N_TERMS single-precision terms into one result using a
//   combinational single-cycle float adder, then holds the result until the
//   consumer takes it.
//
//   Parameters:
//     N_TERMS     terms summed per result (2..255)
//   Ports:
//     clk         sole clock, rising edge
//     reset       synchronous, active-high
//     in_data     32-bit IEEE-754 single term
//     in_valid    in_data holds a term
//     in_ready    block accepts a term this cycle (ACCUM state)
//     out_data    last completed result
//     out_valid   out_data holds a completed result (HOLD state)
//     out_ready   consumer takes the result this cycle
//     term_count  terms accepted into the current result
//
//   Optional feature macro: FLOAT_ACC_RELU_EN
//     defined   -> a negative completed result is presented as +0
//     undefined -> the result is presented unmodified
module float_accumulator #(
    parameter int N_TERMS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  term_count
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    // Float add: all-zero operand passes the other through, mantissa bits
    // shifted out are truncated, no NaN/Inf/denormal handling.
    function automatic logic [31:0] float_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d, e;
        logic [24:0] mx, my, m;
        logic [4:0]  p;
        res = 32'h0;
        if (a == 32'h0) begin
            res = b;
        end else if (b == 32'h0) begin
            res = a;
        end else begin
            // x is the operand of larger magnitude; result takes its sign
            if (a[30:0] >= b[30:0]) begin x = a; y = b; end
            else                    begin x = b; y = a; end
            ex = x[30:23];
            ey = y[30:23];
            d  = ex - ey;
            mx = {2'b01, x[22:0]};
            my = (d > 8'd24) ? 25'h0 : ({2'b01, y[22:0]} >> d);
            e  = ex;
            if (x[31] == y[31]) begin
                m = mx + my;
                if (m[24]) begin
                    m = m >> 1;
                    e = e + 8'd1;
                end
                res = {x[31], e, m[22:0]};
            end else begin
                m = mx - my;
                if (m != 25'h0) begin
                    // locate leading one and renormalise to bit 23
                    p = 5'd0;
                    for (int i = 0; i < 24; i++)
                        if (m[i]) p = 5'(i);
                    m = m << (5'd23 - p);
                    e = e - {3'b000, 5'd23 - p};
                    res = {x[31], e, m[22:0]};
                end
            end
        end
        return res;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_acc;
    logic [31:0] r_result;
    logic [7:0]  r_count;
    logic [31:0] w_sum;
    logic        w_accept;
    logic        w_last;
    logic        w_release;

    assign w_sum     = float_add(r_acc, in_data);
    assign w_accept  = in_valid && (r_state == ACCUM);
    assign w_last    = (r_count == 8'(N_TERMS - 1));
    assign w_release = out_ready && (r_state == HOLD);

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ACCUM;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && w_last) w_next = HOLD;
            HOLD:    if (w_release)          w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    // output logic
    always_comb begin
        in_ready   = (r_state == ACCUM);
        out_valid  = (r_state == HOLD);
        term_count = r_count;
`ifdef FLOAT_ACC_RELU_EN
        out_data   = r_result[31] ? 32'h0 : r_result;
`else
        out_data   = r_result;
`endif
    end

    // datapath: running sum, term counter, completed-result register.
    // r_result only loads on the completing term, so it stays valid through
    // the next accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= 32'h0;
            r_count  <= 8'h0;
            r_result <= 32'h0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= r_count + 8'd1;
            if (w_last) r_result <= w_sum;
        end else if (w_release) begin
            r_acc   <= 32'h0;
            r_count <= 8'h0;
        end
    end

endmodule

// File: tb/tb_float_accumulator.sv
module tb_float_accumulator;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  term_count;

    int n_cmp;
    int n_err;

    float_accumulator #(.N_TERMS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .term_count (term_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // advance one clock; sample point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [31:0] neg_exp;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  {31'h0, in_ready},   32'd1);
        chk("rst_out_valid", {31'h0, out_valid},  32'd0);
        chk("rst_out_data",  out_data,            32'h0);
        chk("rst_count",     {24'h0, term_count}, 32'd0);
        reset = 1'b0;
        step();

        // 1 + 2 + (-1) = 2, back to back
        send(32'h3F800000);
        chk("t1_count1", {24'h0, term_count}, 32'd1);
        send(32'h40000000);
        chk("t1_count2", {24'h0, term_count}, 32'd2);
        chk("t1_novalid", {31'h0, out_valid}, 32'd0);
        send(32'hBF800000);
        chk("t1_valid",    {31'h0, out_valid},  32'd1);
        chk("t1_data",     out_data,            32'h40000000);
        chk("t1_count3",   {24'h0, term_count}, 32'd3);
        chk("t1_in_ready", {31'h0, in_ready},   32'd0);

        // backpressure: result held, offered terms ignored
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data",     out_data,            32'h40000000);
            chk("bp_in_ready", {31'h0, in_ready},   32'd0);
            chk("bp_count",    {24'h0, term_count}, 32'd3);
            chk("bp_valid",    {31'h0, out_valid},  32'd1);
        end
        in_valid = 1'b0;
        take();
        chk("rel_valid",    {31'h0, out_valid},  32'd0);
        chk("rel_in_ready", {31'h0, in_ready},   32'd1);
        chk("rel_count",    {24'h0, term_count}, 32'd0);
        chk("rel_data",     out_data,            32'h40000000);

        // new result sums only fresh terms: 1 + 1 + 2 = 4
        send(32'h3F800000);
        chk("t2_hold_prev", out_data, 32'h40000000);
        send(32'h3F800000);
        send(32'h40000000);
        chk("t2_valid", {31'h0, out_valid}, 32'd1);
        chk("t2_data",  out_data,           32'h40800000);
        take();

        // (-1) * 3 = -3, clamped to 0 when ReLU is built in
`ifdef FLOAT_ACC_RELU_EN
        neg_exp = 32'h00000000;
`else
        neg_exp = 32'hC0400000;
`endif
        send(32'hBF800000);
        send(32'hBF800000);
        send(32'hBF800000);
        chk("t3_valid", {31'h0, out_valid}, 32'd1);
        chk("t3_data",  out_data,           neg_exp);
        take();

        // reset mid-accumulation discards partial sum
        send(32'h3F800000);
        send(32'h3F800000);
        chk("t4_count2", {24'h0, term_count}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_rst_count", {24'h0, term_count}, 32'd0);
        chk("t4_rst_data",  out_data,            32'h0);
        chk("t4_rst_ready", {31'h0, in_ready},   32'd1);
        send(32'h3F800000);
        send(32'h3F800000);
        send(32'h3F800000);
        chk("t4_valid", {31'h0, out_valid}, 32'd1);
        chk("t4_data",  out_data,           32'h40400000);

        // reset in HOLD wins over in_valid and out_ready
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h40000000;
        out_ready = 1'b1;
        step();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t5_valid", {31'h0, out_valid},  32'd0);
        chk("t5_count", {24'h0, term_count}, 32'd0);
        chk("t5_data",  out_data,            32'h0);

        // zeros with idle gaps
        send(32'h00000000);
        chk("t6_c1", {24'h0, term_count}, 32'd1);
        step();
        step();
        chk("t6_c1_idle", {24'h0, term_count}, 32'd1);
        send(32'h00000000);
        chk("t6_c2", {24'h0, term_count}, 32'd2);
        step();
        chk("t6_c2_idle", {24'h0, term_count}, 32'd2);
        chk("t6_novalid", {31'h0, out_valid},  32'd0);
        send(32'h00000000);
        chk("t6_valid", {31'h0, out_valid},  32'd1);
        chk("t6_data",  out_data,            32'h0);
        chk("t6_c3",    {24'h0, term_count}, 32'd3);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
